// File: rtl/coord_frame_buffer.sv
// ============================================================================
// coord_frame_buffer -- unpacks {x,y,z} frames into a tagged DEPTH-entry FIFO
// Optional out-of-range rejection: define COORD_RANGE_CHECK_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module coord_frame_buffer #(
  parameter int                 COORD_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter logic [COORD_W-1:0] MAX_COORD = 16'h7FFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3*COORD_W-1:0]     data_in,
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  output logic [COORD_W-1:0]       x_coord,
  output logic [COORD_W-1:0]       y_coord,
  output logic [COORD_W-1:0]       z_coord,
  output logic [7:0]               seq_tag,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 3*COORD_W + 8;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_seq;

  logic               w_full;
  logic               w_empty;
  logic               w_in_fire;
  logic               w_reject;
  logic               w_store;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_in_fire = data_in_valid && !w_full;
  assign w_store   = w_in_fire && !w_reject;
  assign w_pop     = data_ready && !w_empty;

`ifdef COORD_RANGE_CHECK_EN
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [COORD_W-1:0] w_z;
  logic [15:0]        r_drop;

  assign w_x      = data_in[3*COORD_W-1:2*COORD_W];
  assign w_y      = data_in[2*COORD_W-1:COORD_W];
  assign w_z      = data_in[COORD_W-1:0];
  assign w_reject = (w_x > MAX_COORD) || (w_y > MAX_COORD) || (w_z > MAX_COORD);

  // Rejection is a bus-level accept, so it still needs ready (i.e. !full).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_in_fire && w_reject && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  assign drop_count = r_drop;
`else
  logic w_unused_max;

  assign w_reject     = 1'b0;
  assign drop_count   = 16'h0000;
  assign w_unused_max = ^MAX_COORD;
`endif

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= {data_in, r_seq};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_seq    <= r_seq + 8'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory contents are never reset, so the head is masked while empty.
  assign w_head        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign x_coord       = w_head[ENTRY_W-1:2*COORD_W+8];
  assign y_coord       = w_head[2*COORD_W+7:COORD_W+8];
  assign z_coord       = w_head[COORD_W+7:8];
  assign seq_tag       = w_head[7:0];
  assign data_valid    = !w_empty;
  assign data_in_ready = !w_full;
  assign fill_level    = r_count;

endmodule

`default_nettype wire
